// File: rtl/hazard_tracker.sv
// Hazard tracker: follows in-flight register writes through E, M and W and
// raises a stall when a D-stage source cannot be served by M/W forwarding.
module hazard_tracker #(
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [4:0]             D_A1,
  input  logic [4:0]             D_A2,
  input  logic                   D_A1use,
  input  logic                   D_A2use,
  input  logic [1:0]             D_Tuse1,
  input  logic [1:0]             D_Tuse2,
  input  logic [4:0]             D_A3,
  input  logic                   D_RegWrite,
  input  logic [1:0]             D_Tnew,
  output logic                   stall,
  output logic [4:0]             E_A3,
  output logic                   E_RegWrite,
  output logic [1:0]             E_Tnew,
  output logic [4:0]             M_A3,
  output logic                   M_RegWrite,
  output logic [1:0]             M_Tnew,
  output logic [4:0]             W_A3,
  output logic                   W_RegWrite,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  logic [4:0]             e_a3_q, e_a3_d, m_a3_q, m_a3_d, w_a3_q, w_a3_d;
  logic                   e_wr_q, e_wr_d, m_wr_q, m_wr_d, w_wr_q, w_wr_d;
  logic [1:0]             e_tn_q, e_tn_d, m_tn_q, m_tn_d;
  logic [STALL_CNT_W-1:0] cnt_q, cnt_d;
  logic                   hit1, hit2, entry_wr;
  logic [1:0]             entry_tn;

  // Stall detection: only producers in E or M that are still too far from done can block
  always_comb begin
    hit1 = D_A1use && (D_A1 != 5'd0) &&
           (((D_A1 == e_a3_q) && e_wr_q && (e_tn_q > D_Tuse1)) ||
            ((D_A1 == m_a3_q) && m_wr_q && (m_tn_q > D_Tuse1)));
    hit2 = D_A2use && (D_A2 != 5'd0) &&
           (((D_A2 == e_a3_q) && e_wr_q && (e_tn_q > D_Tuse2)) ||
            ((D_A2 == m_a3_q) && m_wr_q && (m_tn_q > D_Tuse2)));
    stall = hit1 || hit2;
  end

  // Next-state: normalise the D entry, advance E->M->W, count stalled cycles
  always_comb begin
    // $0 writes are dropped; Tnew floors at 1 since E never forwards
    entry_wr = D_RegWrite && (D_A3 != 5'd0);
    entry_tn = (D_Tnew == 2'd0) ? 2'd1 : D_Tnew;
    e_a3_d   = D_A3;
    e_wr_d   = entry_wr;
    e_tn_d   = entry_tn;
    if (stall) begin
      e_a3_d = 5'd0;
      e_wr_d = 1'b0;
      e_tn_d = 2'd0;
    end
    m_a3_d = e_a3_q;
    m_wr_d = e_wr_q;
    m_tn_d = (e_tn_q != 2'd0) ? e_tn_q - 2'd1 : 2'd0;
    w_a3_d = m_a3_q;
    w_wr_d = m_wr_q;
    cnt_d  = cnt_q;
    if (stall && (cnt_q != {STALL_CNT_W{1'b1}})) begin
      cnt_d = cnt_q + STALL_CNT_W'(1);
    end
  end

  // Pipeline tracking registers and counter, synchronously cleared
  always_ff @(posedge clk) begin
    if (reset) begin
      e_a3_q <= 5'd0;
      e_wr_q <= 1'b0;
      e_tn_q <= 2'd0;
      m_a3_q <= 5'd0;
      m_wr_q <= 1'b0;
      m_tn_q <= 2'd0;
      w_a3_q <= 5'd0;
      w_wr_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      e_a3_q <= e_a3_d;
      e_wr_q <= e_wr_d;
      e_tn_q <= e_tn_d;
      m_a3_q <= m_a3_d;
      m_wr_q <= m_wr_d;
      m_tn_q <= m_tn_d;
      w_a3_q <= w_a3_d;
      w_wr_q <= w_wr_d;
      cnt_q  <= cnt_d;
    end
  end

  assign E_A3       = e_a3_q;
  assign E_RegWrite = e_wr_q;
  assign E_Tnew     = e_tn_q;
  assign M_A3       = m_a3_q;
  assign M_RegWrite = m_wr_q;
  assign M_Tnew     = m_tn_q;
  assign W_A3       = w_a3_q;
  assign W_RegWrite = w_wr_q;
  assign stall_cnt  = cnt_q;

endmodule
